// File: rtl/registrador_historico_n.sv
// registrador_historico_n
// ---------------------------------------------------------------------------
// History register. It keeps the last DEPTH loaded N-bit words as a stack
// with the newest word at position 0. It supports push (enable), undo/pop
// (undo), and overwrite of the newest entry (enable and undo together).
// Any stored word can be read back through the index port.
//
// Every position at or beyond the valid count holds INIT_VALUE. A read of an
// unused slot therefore returns the initial value. A pop followed by a push
// leaves the stack consistent.
//
// Ports
//   clock    : single clock, all state changes on the rising edge
//   clear    : synchronous active-high reset to the initial state
//   enable   : push D as the newest entry
//   undo     : pop the newest entry (overwrite when enable is also 1)
//   D        : data to push or overwrite
//   index    : read select, 0 = newest
//   Q        : newest entry (registered)
//   Q_index  : entry[index], or INIT_VALUE when index >= DEPTH (combinational)
//   count    : number of valid entries, 0..DEPTH (registered)
//   empty    : count == 0 (registered)
//   full     : count == DEPTH (registered)
// ---------------------------------------------------------------------------
module registrador_historico_n #(
  parameter int            N          = 8,
  parameter int            DEPTH      = 4,
  parameter logic [N-1:0]  INIT_VALUE = '0,
  localparam int           W          = $clog2(DEPTH),
  localparam int           C          = $clog2(DEPTH + 1)
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         enable,
  input  logic         undo,
  input  logic [N-1:0] D,
  input  logic [W-1:0] index,
  output logic [N-1:0] Q,
  output logic [N-1:0] Q_index,
  output logic [C-1:0] count,
  output logic         empty,
  output logic         full
);

  localparam logic [C-1:0] DEPTH_C = C'(DEPTH);
  localparam logic [C-1:0] ZERO_C  = C'(0);
  localparam logic [C-1:0] ONE_C   = C'(1);
  localparam logic [W:0]   DEPTH_W = (W + 1)'(DEPTH);

  // The declaration initialisers make the power-up contents equal the
  // reset state, so no clear pulse is needed before first use.
  logic [N-1:0] entry_r [DEPTH] = '{default: INIT_VALUE};
  logic [C-1:0] count_r         = ZERO_C;
  logic         empty_r         = 1'b1;
  logic         full_r          = 1'b0;

  logic [N-1:0] entry_n_s [DEPTH];
  logic [C-1:0] count_n_s;
  logic [N-1:0] q_index_s;

  // Next-state computation for push, pop, overwrite and hold.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_n_s[i] = entry_r[i];
    end
    count_n_s = count_r;

    case ({enable, undo})
      2'b10: begin
        // Push. When the stack is full, the oldest word falls off the end.
        entry_n_s[0] = D;
        for (int i = 1; i < DEPTH; i++) begin
          entry_n_s[i] = entry_r[i-1];
        end
        if (count_r == DEPTH_C) begin
          count_n_s = count_r;
        end else begin
          count_n_s = count_r + ONE_C;
        end
      end
      2'b01: begin
        // Pop. The vacated top slot is refilled with INIT_VALUE so that the
        // invariant holds. A pop on an empty stack changes nothing.
        if (count_r != ZERO_C) begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            entry_n_s[i] = entry_r[i+1];
          end
          entry_n_s[DEPTH-1] = INIT_VALUE;
          count_n_s          = count_r - ONE_C;
        end else begin
          count_n_s = count_r;
        end
      end
      2'b11: begin
        // Overwrite the newest entry in place. On an empty stack this
        // creates the first entry.
        entry_n_s[0] = D;
        if (count_r == ZERO_C) begin
          count_n_s = ONE_C;
        end else begin
          count_n_s = count_r;
        end
      end
      default: begin
        count_n_s = count_r;
      end
    endcase
  end

  // State registers. Clear takes priority over any pending operation.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= INIT_VALUE;
      end
      count_r <= ZERO_C;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= entry_n_s[i];
      end
      count_r <= count_n_s;
      empty_r <= (count_n_s == ZERO_C);
      full_r  <= (count_n_s == DEPTH_C);
    end
  end

  // Random read port. An index beyond DEPTH, which is only possible when
  // DEPTH is not a power of two, returns the initial value.
  always_comb begin
    q_index_s = INIT_VALUE;
    if ({1'b0, index} < DEPTH_W) begin
      q_index_s = entry_r[index];
    end else begin
      q_index_s = INIT_VALUE;
    end
  end

  assign Q       = entry_r[0];
  assign Q_index = q_index_s;
  assign count   = count_r;
  assign empty   = empty_r;
  assign full    = full_r;

endmodule

// File: doc/registrador_historico_n.md
# registrador_historico_n

Parametrised history register: a depth-DEPTH stack of N-bit words with per-block initial value, synchronous load (push), undo (pop) and overwrite, plus random read access to any past value. It is the successor of the single N-bit initial-value register in the datapath. It serves game/sequence logic that must remember the last DEPTH loaded values and roll back moves without external RAM.

## Interface
- N, 8, word width in bits (≥1)
- DEPTH, 4, number of stored entries (≥2)
- INIT_VALUE, 0, N-bit value loaded into every entry on reset, on power-up and into vacated slots
- W (localparam), $clog2(DEPTH), index width
- C (localparam), $clog2(DEPTH+1), count width
- clock  in  1  single clock; all state changes on rising edge
- clear  in  1  reset, synchronous, active-high: sampled on rising edge of clock only
- enable  in  1  push D as newest entry
- undo  in  1  pop newest entry
- D  in  N  data to push/overwrite
- index  in  W  read select, 0 = newest
- Q  out  N  entry 0 (newest)
- Q_index  out  N  entry[index]
- count  out  C  number of valid entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- State: entry[0..DEPTH-1] (N bits each), count (C bits). Power-up contents equal the reset state.
- Reset state: every entry = INIT_VALUE, count = 0, so empty = 1, full = 0, Q = Q_index = INIT_VALUE.
- Per rising edge, priority order:
  - clear = 1 → reset state, regardless of enable/undo.
  - enable = 1, undo = 0 (push):
    - entry[i] ← entry[i-1] for i ≥ 1, and entry[0] ← D.
    - count ← min(count+1, DEPTH). When full, the oldest entry is discarded and count stays DEPTH.
  - enable = 0, undo = 1 (pop):
    - If count > 0: entry[i] ← entry[i+1] for i < DEPTH-1, entry[DEPTH-1] ← INIT_VALUE, count ← count-1.
    - If count = 0: no change.
  - enable = 1, undo = 1 (overwrite): entry[0] ← D with no shift. count ← max(count, 1).
  - Neither asserted: hold.
- Invariant: every entry at position ≥ count holds INIT_VALUE.
  - Reading an invalid slot returns INIT_VALUE.
  - Pop then push restores a consistent stack.
- Q_index: entry[index] when index < DEPTH. When index ≥ DEPTH (DEPTH not a power of two), Q_index = INIT_VALUE.
- empty and full are decoded from count. They are never both 1, since DEPTH ≥ 2.

## Timing
- Update latency 1 clock: effects of enable/undo/clear at edge k are visible on Q, Q_index, count, empty and full right after edge k.
- Q, count, empty and full are driven directly from registers, with no combinational path from inputs.
- Q_index is a combinational mux of the registered entries by index.
  - Changing index changes Q_index in the same cycle.
  - There is no path from D, enable or undo to Q_index.
- Back-to-back operations are allowed every cycle, with no bubbles or busy state.
- Reset mid-sequence (clear with enable/undo active) discards the pending operation. The next edge with clear = 0 operates on the reset state.
- D is sampled only on the edge where enable = 1.

## Test plan
- Params N=8, DEPTH=4, INIT_VALUE=8'hA5, unless stated otherwise.
- Reset/power-up: check before any edge, then with clear pulsed for one edge → Q = Q_index(any index) = A5, count = 0, empty = 1, full = 0.
- Fill and overflow:
  - Push 01, 02, 03, 04 → count = 4, full = 1, Q_index[0..3] = 04, 03, 02, 01.
  - Then push 05 → count = 4, entries = 05, 04, 03, 02 (01 discarded).
- Undo to empty:
  - From 05, 04, 03, 02, pop ×4 → count steps 3, 2, 1, 0 and Q steps 04, 03, 02, A5. All entries = A5.
  - A 5th pop leaves count = 0 and empty = 1 unchanged.
- Overwrite:
  - Push 10, 20, then enable = undo = 1 with D = 7F → count = 2, entries 7F, 10, A5, A5.
  - Overwrite from empty with D = 33 → count = 1, Q = 33.
- Sync reset priority: with count = 3, assert clear = 1 together with enable = 1 and D = EE → next state is the reset state and EE is not stored. Clear asserted between edges has no effect until the edge.
- Non-power-of-two depth (DEPTH=3, so W=2): after pushing 01, 02, 03, index = 3 → Q_index = A5 and index = 2 → 01.
